// File: rtl/dot_accum_pkg.sv
// Shared types and width/limit helpers for the dot-product accumulator.
package dot_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int acc_w(input int data_w, input int guard);
        return data_w + guard;
    endfunction

    function automatic longint max_val(input int data_w);
        return (longint'(1) <<< (data_w - 1)) - longint'(1);
    endfunction

    function automatic longint min_val(input int data_w);
        return -(longint'(1) <<< (data_w - 1));
    endfunction

endpackage

// File: rtl/sat_narrow.sv
// Saturating ACC_W -> DATA_WIDTH narrowing with clip flag.
// Only built when DOT_ACCUM_SAT_EN is defined.
`ifdef DOT_ACCUM_SAT_EN
module sat_narrow
    import dot_accum_pkg::*;
#(
    parameter int IN_W  = 20,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  acc_i,
    output logic [OUT_W-1:0] data_o,
    output logic             clip_o
);
    localparam logic signed [IN_W-1:0] HI = IN_W'(max_val(OUT_W));
    localparam logic signed [IN_W-1:0] LO = IN_W'(min_val(OUT_W));

    // Result packed as {clip, data}.
    function automatic logic [OUT_W:0] sat_fn(input logic signed [IN_W-1:0] v);
        if (v > HI) return {1'b1, HI[OUT_W-1:0]};
        if (v < LO) return {1'b1, LO[OUT_W-1:0]};
        return {1'b0, v[OUT_W-1:0]};
    endfunction

    assign {clip_o, data_o} = sat_fn($signed(acc_i));

endmodule
`endif

// File: rtl/dot_accum.sv
// Sums VEC_LEN fixed-point products (with multiplier overflow substitution) into one result.
// Define DOT_ACCUM_SAT_EN to saturate the narrowed result instead of wrapping.
module dot_accum
    import dot_accum_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PNT  = 8,
    parameter int VEC_LEN    = 8,
    parameter int ACC_GUARD  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] product,
    input  logic                  overflow,
    input  logic                  underflow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sat
);
    localparam int ACC_W = acc_w(DATA_WIDTH, ACC_GUARD);
    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic signed [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(max_val(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] MIN_V = DATA_WIDTH'(min_val(DATA_WIDTH));

    // Guard bits must cover the worst-case sum so the accumulator itself never wraps.
    if (VEC_LEN < 1 || VEC_LEN > (1 << ACC_GUARD)) begin : g_bad_len
        $fatal(1, "dot_accum: VEC_LEN must be in 1..2**ACC_GUARD");
    end
    if (FIXED_PNT < 0 || FIXED_PNT >= DATA_WIDTH) begin : g_bad_fp
        $fatal(1, "dot_accum: FIXED_PNT must be in 0..DATA_WIDTH-1");
    end

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, term;
    logic signed [DATA_WIDTH-1:0] term_n;
    logic                    flag_q, flag_d;
    logic                    beat, last;
    logic [DATA_WIDTH-1:0]   out_data_q, narrow_d;
    logic                    out_sat_q, out_valid_q, clip_d;

    assign in_ready = (state_q != DONE);
    assign beat     = in_valid && in_ready;

    // Overflow takes priority when the multiplier raises both flags.
    always_comb begin
        term_n = $signed(product);
        if (overflow)       term_n = MAX_V;
        else if (underflow) term_n = MIN_V;
    end

    assign term   = {{ACC_GUARD{term_n[DATA_WIDTH-1]}}, term_n};
    assign acc_d  = acc_q + term;
    assign cnt_d  = cnt_q + CNT_W'(1);
    assign flag_d = flag_q | overflow | underflow;
    assign last   = (cnt_d == CNT_W'(VEC_LEN));

`ifdef DOT_ACCUM_SAT_EN
    sat_narrow #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_WIDTH)
    ) u_sat (
        .acc_i  (acc_d),
        .data_o (narrow_d),
        .clip_o (clip_d)
    );
`else
    logic unused_guard;
    assign narrow_d     = acc_d[DATA_WIDTH-1:0];
    assign clip_d       = 1'b0;
    assign unused_guard = ^acc_d[ACC_W-1:DATA_WIDTH];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            flag_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat) begin
                        acc_q  <= acc_d;
                        cnt_q  <= cnt_d;
                        flag_q <= flag_d;
                        if (last) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= narrow_d;
                            out_sat_q   <= clip_d | flag_d;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        flag_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_dot_accum.sv
// Randomized self-checking bench for dot_accum against an arithmetic reference model.
module tb_dot_accum;
    localparam int DW = 16;
    localparam int VL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [DW-1:0] product;
    logic          overflow, underflow;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic          out_sat;

    int n_chk  = 0;
    int n_fail = 0;
    int hs_cnt = 0;

    logic [DW-1:0] vp [VL];
    logic          vo [VL];
    logic          vu [VL];

    always #5 clk = ~clk;

    dot_accum #(
        .DATA_WIDTH (DW),
        .FIXED_PNT  (8),
        .VEC_LEN    (VL),
        .ACC_GUARD  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .overflow  (overflow),
        .underflow (underflow),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always @(posedge clk) if (rst_n && out_valid && out_ready) hs_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integer sum of substituted terms, then narrow.
    task automatic model(output logic [DW-1:0] d, output logic s);
        longint sum  = 0;
        logic   flag = 1'b0;
        logic   clip = 1'b0;
        for (int i = 0; i < VL; i++) begin
            if (vo[i])      sum += 32767;
            else if (vu[i]) sum -= 32768;
            else            sum += longint'($signed(vp[i]));
            flag |= vo[i] | vu[i];
        end
`ifdef DOT_ACCUM_SAT_EN
        if (sum > 32767)       begin sum = 32767;  clip = 1'b1; end
        else if (sum < -32768) begin sum = -32768; clip = 1'b1; end
`endif
        d = sum[DW-1:0];
        s = flag | clip;
    endtask

    task automatic set_vec(input logic [DW-1:0] a, b, c, d);
        vp[0] = a; vp[1] = b; vp[2] = c; vp[3] = d;
        for (int i = 0; i < VL; i++) begin
            vo[i] = 1'b0;
            vu[i] = 1'b0;
        end
    endtask

    task automatic beat(input logic [DW-1:0] p, input logic o, input logic u, input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; product = p; overflow = o; underflow = u;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        product   = 16'($urandom);
        overflow  = 1'($urandom_range(1));
        underflow = 1'($urandom_range(1));
    endtask

    task automatic run_vec(input int gap_pct, input int hold, input string tag);
        logic [DW-1:0] ed;
        logic          es;
        model(ed, es);
        for (int i = 0; i < VL; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                @(posedge clk); #1;
            end
            beat(vp[i], vo[i], vu[i], tag);
            if (i < VL - 1) chk({tag, "_early_valid"}, out_valid, 0);
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_sat"}, out_sat, es);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            product  = 16'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_data"}, out_data, ed);
            chk({tag, "_hold_sat"}, out_sat, es);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, out_valid, 0);
        chk({tag, "_post_in_ready"}, in_ready, 1);
    endtask

    task automatic pulse_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_sat"}, out_sat, 0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int hs0;
        rst_n = 1'b0; in_valid = 1'b0; product = '0;
        overflow = 1'b0; underflow = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", out_data, 0);
        chk("rst_sat", out_sat, 0);
        rst_n = 1'b1;

        set_vec(16'h0100, 16'h0200, 16'hFF00, 16'h0080);
        run_vec(0, 0, "basic");

        set_vec(16'h7000, 16'h7000, 16'h7000, 16'h7000);
        run_vec(0, 0, "big");

        set_vec(16'h0000, 16'h1234, 16'h0000, 16'h0000);
        vo[1] = 1'b1;
        run_vec(0, 0, "ovf");
        set_vec(16'h0000, 16'h1234, 16'h0000, 16'h0000);
        vu[1] = 1'b1;
        run_vec(0, 0, "udf");
        set_vec(16'h0000, 16'h1234, 16'h0000, 16'h0000);
        vo[1] = 1'b1; vu[1] = 1'b1;
        run_vec(0, 0, "both");

        set_vec(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        run_vec(0, 5, "hold");
        set_vec(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        run_vec(0, 0, "after_hold");

        beat(16'h0100, 1'b0, 1'b0, "mid");
        beat(16'h0100, 1'b0, 1'b0, "mid");
        pulse_reset("rst_mid");
        set_vec(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        run_vec(0, 0, "post_rst");

        for (int i = 0; i < VL; i++) beat(16'h1111, 1'b0, 1'b0, "done_fill");
        chk("done_fill_valid", out_valid, 1);
        pulse_reset("rst_done");
        set_vec(16'h0040, 16'hFFC0, 16'h0020, 16'h0001);
        run_vec(0, 0, "post_rst_done");

        hs0 = hs_cnt;
        set_vec(16'h0040, 16'h0040, 16'h0040, 16'h0040);
        run_vec(50, 0, "gaps");
        chk("gaps_handshakes", 32'(hs_cnt - hs0), 1);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < VL; i++) begin
                vp[i] = $urandom_range(1) ? 16'($urandom) : 16'(int'($urandom_range(511)) - 256);
                vo[i] = ($urandom_range(7) == 0);
                vu[i] = ($urandom_range(7) == 0);
            end
            run_vec($urandom_range(1) * 50, int'($urandom_range(3)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
